// File: rtl/switch_nport_core_if.sv
// Bundle of the switch core's port-side signals: per-input flit request/accept
// and per-output show-ahead queue heads with a valid/ready drain handshake.
interface switch_nport_core_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_PORTS-1:0]        in_valid;
    logic [NUM_PORTS*PW-1:0]     in_dest;
    logic [NUM_PORTS*DATA_W-1:0] in_data;
    logic [NUM_PORTS-1:0]        in_ready;
    logic [NUM_PORTS-1:0]        out_valid;
    logic [NUM_PORTS-1:0]        out_ready;
    logic [NUM_PORTS*DATA_W-1:0] out_data;
    logic [NUM_PORTS*PW-1:0]     out_src;
    logic [NUM_PORTS*LW-1:0]     out_level;

    // Port-side agents drive flits in and accept heads out.
    modport master (
        output in_valid, in_dest, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, out_level
    );

    // The switch core accepts flits and presents queue heads.
    modport slave (
        input  in_valid, in_dest, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, out_level
    );
endinterface

// File: rtl/switch_nport_core.sv
// N-port packet switch core. Each output owns a round-robin arbiter over all
// inputs and a show-ahead FIFO of {source, payload} entries. Fullness is taken
// from the registered level, so a full queue refuses a push even while popping.
module switch_nport_core #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    switch_nport_core_if.slave bus
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = LW - 1;
    localparam int EW = PW + DATA_W;

    // Grant matrix, bit [o*NUM_PORTS + i] set when output o grants input i.
    logic [NUM_PORTS*NUM_PORTS-1:0] gnt_flat;
    logic [NUM_PORTS-1:0]           in_ready_d;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            logic [EW-1:0]        mem_q [FIFO_DEPTH];
            logic [AW-1:0]        wr_ptr_q;
            logic [AW-1:0]        rd_ptr_q;
            logic [LW-1:0]        level_q;
            logic [PW-1:0]        rr_q;
            logic [NUM_PORTS-1:0] gnt_d;
            logic [PW-1:0]        gsel_d;
            logic [PW-1:0]        idx_d;
            logic                 found_d;
            logic                 push;
            logic                 pop;
            logic                 valid;
            logic [EW-1:0]        head;

            // Round-robin search from rr_q upward with wrap; grant only when the queue has room.
            always_comb begin
                gnt_d   = '0;
                gsel_d  = '0;
                idx_d   = '0;
                found_d = 1'b0;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx_d = rr_q + PW'(k);
                    if (!found_d && bus.in_valid[idx_d] &&
                        bus.in_dest[idx_d*PW +: PW] == PW'(gi)) begin
                        found_d = 1'b1;
                        gsel_d  = idx_d;
                    end
                end
                if (found_d && (level_q < LW'(FIFO_DEPTH)) && !rst) begin
                    gnt_d[gsel_d] = 1'b1;
                end
            end

            assign push  = |gnt_d;
            assign valid = (level_q != '0);
            assign pop   = valid && bus.out_ready[gi];

            // Queue bookkeeping and arbiter pointer; reset discards all queued flits.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    level_q  <= '0;
                    rr_q     <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        rr_q     <= gsel_d + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                    if (push && !pop) begin
                        level_q <= level_q + 1'b1;
                    end else if (pop && !push) begin
                        level_q <= level_q - 1'b1;
                    end
                end
            end

            // Entry storage; the source index travels with the payload.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= {gsel_d, bus.in_data[gsel_d*DATA_W +: DATA_W]};
                end
            end

            // Show-ahead head, forced to zero while the queue is empty.
            assign head = mem_q[rd_ptr_q];
            assign bus.out_valid[gi]                 = valid;
            assign bus.out_data[gi*DATA_W +: DATA_W] = valid ? head[DATA_W-1:0] : '0;
            assign bus.out_src[gi*PW +: PW]          = valid ? head[EW-1 -: PW] : '0;
            assign bus.out_level[gi*LW +: LW]        = level_q;
            assign gnt_flat[gi*NUM_PORTS +: NUM_PORTS] = gnt_d;
        end
    endgenerate

    // An input is ready when the arbiter of its destination granted it.
    always_comb begin
        in_ready_d = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            in_ready_d = in_ready_d | gnt_flat[o*NUM_PORTS +: NUM_PORTS];
        end
    end

    assign bus.in_ready = in_ready_d;
endmodule

// File: tb/tb_switch_nport_core.sv
// Randomised and directed bench for switch_nport_core against a queue-based
// reference model of the per-output round-robin switch.
module tb_switch_nport_core;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 8;
    localparam int PW = 2;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst;

    switch_nport_core_if #(.NUM_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(D)) bus ();

    switch_nport_core #(.NUM_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue of {src, data} per output plus a pointer per arbiter.
    logic [PW+DW-1:0] q_m [N][$];
    int               rr_m [N];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*PW-1:0] dests(input int d0, input int d1, input int d2, input int d3);
        logic [N*PW-1:0] v;
        v = {PW'(d3), PW'(d2), PW'(d1), PW'(d0)};
        return v;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance both.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*PW-1:0] d,
                        input logic [N*DW-1:0] dat, input logic [N-1:0] ordy,
                        output logic [N-1:0] rdy_obs);
        int           gsel [N];
        logic [N-1:0] er;
        rst           = r;
        bus.in_valid  = v;
        bus.in_dest   = d;
        bus.in_data   = dat;
        bus.out_ready = ordy;
        #1;
        er = '0;
        for (int o = 0; o < N; o++) begin
            gsel[o] = -1;
            if (!r && q_m[o].size() < D) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (rr_m[o] + k) % N;
                    if (gsel[o] < 0 && v[i] && int'(d[i*PW +: PW]) == o) gsel[o] = i;
                end
            end
            if (gsel[o] >= 0) er[gsel[o]] = 1'b1;
        end
        rdy_obs = bus.in_ready;
        check_eq("in_ready", bus.in_ready, er);
        for (int o = 0; o < N; o++) begin
            check_eq($sformatf("out_level[%0d]", o), bus.out_level[o*LW +: LW], q_m[o].size());
            check_eq($sformatf("out_valid[%0d]", o), bus.out_valid[o], q_m[o].size() != 0);
            if (q_m[o].size() != 0) begin
                check_eq($sformatf("out_data[%0d]", o), bus.out_data[o*DW +: DW], q_m[o][0][DW-1:0]);
                check_eq($sformatf("out_src[%0d]", o), bus.out_src[o*PW +: PW], q_m[o][0][PW+DW-1:DW]);
                if (ordy[o] && !r)
                    $display("deliver out=%0d src=%0d data=%02h level=%0d", o,
                             q_m[o][0][PW+DW-1:DW], q_m[o][0][DW-1:0], q_m[o].size());
            end
        end
        @(posedge clk);
        for (int o = 0; o < N; o++) begin
            if (r) begin
                q_m[o].delete();
                rr_m[o] = 0;
            end else begin
                if (q_m[o].size() != 0 && ordy[o]) void'(q_m[o].pop_front());
                if (gsel[o] >= 0) begin
                    q_m[o].push_back({PW'(gsel[o]), dat[gsel[o]*DW +: DW]});
                    rr_m[o] = (gsel[o] + 1) % N;
                end
            end
        end
        @(negedge clk);
    endtask

    logic [N-1:0]    rdy;
    logic [N*DW-1:0] dat;

    initial begin
        rst = 1'b1;
        bus.in_valid = '0; bus.in_dest = '0; bus.in_data = '0; bus.out_ready = '0;
        for (int o = 0; o < N; o++) rr_m[o] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held two cycles with every input requesting.
        repeat (2) begin
            step(1'b1, 4'b1111, dests(0, 1, 2, 3), 32'h44332211, 4'b1111, rdy);
            check_eq("reset_ready", rdy, 4'b0000);
        end
        check_eq("reset_level", bus.out_level, '0);
        check_eq("reset_valid", bus.out_valid, '0);
        check_eq("reset_data", bus.out_data, '0);
        step(1'b0, 4'b1111, dests(0, 1, 2, 3), 32'h44332211, 4'b1111, rdy);
        check_eq("release_ready", rdy, 4'b1111);
        repeat (2) step(1'b0, 4'b0000, '0, '0, 4'b1111, rdy);

        // Unicast 0xA5 from port 0 to output 2.
        step(1'b0, 4'b0001, dests(2, 0, 0, 0), 32'h000000A5, 4'b1111, rdy);
        check_eq("uni_valid", bus.out_valid, 4'b0100);
        check_eq("uni_data", bus.out_data[2*DW +: DW], 8'hA5);
        check_eq("uni_src", bus.out_src[2*PW +: PW], 0);
        step(1'b0, 4'b0000, '0, '0, 4'b1111, rdy);
        check_eq("uni_once", bus.out_valid, 4'b0000);

        // Contention: all inputs to output 1 from a fresh pointer.
        step(1'b1, 4'b0000, '0, '0, 4'b0000, rdy);
        for (int c = 0; c < 8; c++) begin
            dat = {8'(c*16+3), 8'(c*16+2), 8'(c*16+1), 8'(c*16)};
            step(1'b0, 4'b1111, dests(1, 1, 1, 1), dat, 4'b0010, rdy);
            check_eq($sformatf("contend_gnt[%0d]", c), rdy, 4'b0001 << (c % 4));
        end
        repeat (2) step(1'b0, 4'b0000, '0, '0, 4'b1111, rdy);

        // Full queue on output 3, then pop-while-full, then drain.
        step(1'b1, 4'b0000, '0, '0, 4'b0000, rdy);
        for (int n = 0; n < 8; n++) step(1'b0, 4'b0001, dests(3, 0, 0, 0), 32'(n), 4'b0000, rdy);
        check_eq("full_level", bus.out_level[3*LW +: LW], 8);
        step(1'b0, 4'b0001, dests(3, 0, 0, 0), 32'h8, 4'b0000, rdy);
        check_eq("full_refuse", rdy[0], 1'b0);
        step(1'b0, 4'b0001, dests(3, 0, 0, 0), 32'h8, 4'b1000, rdy);
        check_eq("full_pop_refuse", rdy[0], 1'b0);
        check_eq("full_pop_level", bus.out_level[3*LW +: LW], 7);
        step(1'b0, 4'b0001, dests(3, 0, 0, 0), 32'h8, 4'b1000, rdy);
        check_eq("full_accept", rdy[0], 1'b1);
        check_eq("full_hold_level", bus.out_level[3*LW +: LW], 7);
        repeat (9) step(1'b0, 4'b0000, '0, '0, 4'b1000, rdy);
        check_eq("full_drained", bus.out_level[3*LW +: LW], 0);

        // Parallel permutation, then mid-operation reset.
        step(1'b1, 4'b0000, '0, '0, 4'b0000, rdy);
        step(1'b0, 4'b1111, dests(1, 0, 3, 2), 32'hD4C3B2A1, 4'b1111, rdy);
        check_eq("par_ready", rdy, 4'b1111);
        check_eq("par_valid", bus.out_valid, 4'b1111);
        step(1'b0, 4'b0000, '0, '0, 4'b1111, rdy);
        for (int n = 0; n < 5; n++) step(1'b0, 4'b0001, dests(2, 0, 0, 0), 32'(n + 16), 4'b0000, rdy);
        check_eq("mid_level", bus.out_level[2*LW +: LW], 5);
        step(1'b1, 4'b0001, dests(2, 0, 0, 0), 32'h99, 4'b0000, rdy);
        check_eq("mid_rst_level", bus.out_level, '0);
        check_eq("mid_rst_valid", bus.out_valid, '0);

        // Randomised traffic with occasional reset.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 99) == 0), 4'($urandom), 8'($urandom), $urandom,
                 4'($urandom) | 4'($urandom), rdy);
        end
        repeat (12) step(1'b0, 4'b0000, '0, '0, 4'b1111, rdy);
        check_eq("final_empty", bus.out_valid, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_nport_core.md
# switch_nport_core

Synthesizable, parametrised N-port packet switch core: the next generation of the fixed 4-port switch, generalised in port count, data width and queue depth. Each input presents one flit per cycle tagged with a binary destination port. Per-output round-robin arbiters admit flits into per-output FIFOs, and each output drains its FIFO over a valid/ready handshake. The core sits directly behind the port interfaces and is exercised by the existing packet VCs, one per port.

## Interface
- NUM_PORTS, 4: number of ports; power of 2, ≥2.
- DATA_W, 8: flit payload width.
- FIFO_DEPTH, 8: entries per output queue; power of 2, ≥2.
- PW (localparam) = $clog2(NUM_PORTS); LW (localparam) = $clog2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_PORTS  input i presents a flit.
- in_dest  in  NUM_PORTS*PW  destination of input i, slice [i*PW +: PW].
- in_data  in  NUM_PORTS*DATA_W  payload of input i.
- in_ready  out  NUM_PORTS  flit of input i accepted this cycle.
- out_valid  out  NUM_PORTS  output o head flit valid.
- out_ready  in  NUM_PORTS  sink of output o accepts head.
- out_data  out  NUM_PORTS*DATA_W  head payload of output o.
- out_src  out  NUM_PORTS*PW  source port of head flit of output o.
- out_level  out  NUM_PORTS*LW  current occupancy of output queue o, 0..FIFO_DEPTH.

## Operation
- A request from input i to output o is in_valid[i] && in_dest[i]==o. Because NUM_PORTS is a power of 2, every destination is legal.
- Arbiter per output o holds pointer rr[o] (PW bits). It searches requesters starting at rr[o], upward with wrap. It grants the first requester found, but only if queue o is not full (level < FIFO_DEPTH, evaluated on the registered level).
- in_ready[i] = 1 when input i is granted by its destination arbiter. in_ready is combinational from in_valid, in_dest and registered state. An input with in_valid=0 has in_ready=0.
- On a grant to input g: push {g, in_data[g]} into queue o, and set rr[o] to (g+1) mod NUM_PORTS. With no grant, rr[o] is held.
- Pop of queue o occurs when out_valid[o] && out_ready[o]. The queue is show-ahead: out_data and out_src reflect the head entry whenever out_valid=1.
- out_valid[o] = (level[o] != 0).
- Level update: push only gives +1, pop only gives −1, push and pop together leave it unchanged.
- Read and write pointers are LW−1 bits and wrap modulo FIFO_DEPTH naturally.
- Ordering is preserved for each (input, output) pair. Different outputs operate fully independently and concurrently.
- Throughput: at most one flit accepted per input per cycle and at most one delivered per output per cycle.

## Timing
- Reset (rst=1 at posedge) empties every queue and sets level=0, out_valid=0 and rr=0. out_data and out_src are don't-care while out_valid=0; they are driven 0 after reset.
- Reset mid-operation discards all queued flits. in_ready=0 during any cycle with rst=1.
- Latency: a flit accepted at edge t into an empty queue gives out_valid=1 with that flit after edge t (visible cycle t+1). There is no bypass path.
- Full queue with a simultaneous pop: the push is refused that cycle, because fullness uses the registered level. The flit is accepted the next cycle. No flit is ever lost or duplicated.
- Empty queue with a simultaneous push: no pop is possible (out_valid=0), and level becomes 1.
- An input holds in_valid, in_dest and in_data stable until in_ready=1. Changing them earlier is allowed, and the core honours whatever is presented in the current cycle.
- Fairness: with K persistent requesters to one output and the sink always ready, each requester is granted at least once every K cycles.

## Test plan
- Reset: hold rst 2 cycles with all in_valid=1 → in_ready=0, out_valid=0, out_level=0 for all ports. After release, first cycle in_ready=1 for every input.
- Unicast: port0 sends data 0xA5 to dest 2 at cycle t, out_ready=1 → out_valid[2]=1, out_data=0xA5, out_src=0 at t+1 only. Other outputs remain invalid.
- Contention: all 4 inputs continuously target dest 1, out_ready[1]=1 → grant sequence 0,1,2,3,0,1… is one per cycle, and out_src[1] follows the same order one cycle later.
- Full: out_ready[3]=0, port0 sends 9 flits 0x00..0x08 to dest 3 → the first 8 are accepted and out_level[3]=8; in_ready[0]=0 on the ninth. Raise out_ready[3]: the queue drains 0x00..0x08 in order, and the ninth is accepted the cycle after the first pop.
- Full plus simultaneous pop: level 8, out_ready=1 and in_valid=1 in the same cycle → that cycle in_ready=0 and level=7 next. The following cycle in_ready=1 and level stays 7.
- Parallel and mid-op reset: ports 0→1, 1→0, 2→3, 3→2 at the same time → all four delivered at t+1. Then with level 5 on one queue, assert rst for 1 cycle → next cycle all levels are 0 and out_valid=0.
